// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: opcodes, hazard FSM state encoding and
// the rt-source decode used by the hazard and pipeline-register logic.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_t;

  // True when the instruction reads rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait holds with a sticky timeout flag.
//
//  state         | meaning
//  --------------+--------------------------------------------------
//  ST_RUN        | normal issue, no hazard outstanding
//  ST_LOAD_STALL | bubble inserted for a load-use, re-check each cycle
//  ST_MEM_WAIT   | data memory busy, pipeline frozen, timer running
//  ST_FLUSH      | one cycle after a flush; load-use from bubble ignored
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       ifid_opcode,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic                err_set;
  logic                load_use;
  logic                timeout;

  // The slot behind a flush is a bubble, so its memread must not stall.
  assign load_use = idex_memread && (idex_rt != 5'd0) && (state != ST_FLUSH) &&
                    ((idex_rt == ifid_rs) ||
                     (uses_rt(ifid_opcode) && (idex_rt == ifid_rt)));

  // Timeout fires on the wait cycle whose increment reaches MEM_TIMEOUT.
  assign timeout = (state == ST_MEM_WAIT) &&
                   ((wait_cnt + WAIT_W'(1)) == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (err_set) begin
        mem_error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = ST_RUN;
    wait_next   = '0;
    err_set     = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;

    if (dmem_busy && timeout) begin
      err_set    = 1'b1;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      state_next = ST_RUN;
    end else if (dmem_busy) begin
      exmem_hold = 1'b1;
      state_next = ST_MEM_WAIT;
      wait_next  = (state == ST_MEM_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
    end else if (ex_branch_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_next  = ST_FLUSH;
    end else if (load_use) begin
      idex_bubble = 1'b1;
      state_next  = ST_LOAD_STALL;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      state_next = ST_RUN;
    end

    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (!pc_write),
    .clear   (1'b0),
    .count   (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (ifid_flush),
    .clear   (1'b0),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, false-stall, branch flush,
// memory wait, timeout and asynchronous reset scenarios.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_HOLD  = 5'b00001;
  localparam logic [4:0] C_ZERO  = 5'b00000;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [5:0]       ifid_opcode = '0;
  logic [4:0]       ifid_rs = '0;
  logic [4:0]       ifid_rt = '0;
  logic             idex_memread = 1'b0;
  logic [4:0]       idex_rt = '0;
  logic             ex_branch_taken = 1'b0;
  logic             dmem_busy = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ifid_opcode     (ifid_opcode),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .idex_memread    (idex_memread),
    .idex_rt         (idex_rt),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_hold      (exmem_hold),
    .mem_error       (mem_error),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clock = ~clock;

  wire [4:0] ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    ifid_opcode = 6'b000000; ifid_rs = 5'd0; ifid_rt = 5'd0;
    idex_memread = 1'b0; idex_rt = 5'd0;
    ex_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  initial begin
    quiet();
    // Reset state
    #12;
    chk("rst_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    chk("rst_mem_error", 32'(mem_error), 32'd0);
    tick();
    reset_n = 1'b1;
    #3;
    chk("idle_run", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("idle_stall_cnt", 32'(stall_count), 32'd0);

    // Load-use via rt on an R-type: one stall cycle, then release
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_opcode = 6'b000000; ifid_rt = 5'd5; ifid_rs = 5'd1;
    #3;
    chk("lu_stall", 32'(ctrl), 32'(C_STALL));
    tick();
    idex_memread = 1'b0;
    #3;
    chk("lu_release", 32'(ctrl), 32'(C_RUN));
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);
    tick();
    chk("lu_stall_cnt_hold", 32'(stall_count), 32'd1);

    // Load-use via rs matches regardless of opcode
    idex_memread = 1'b1; idex_rt = 5'd7; ifid_opcode = 6'b001001; ifid_rs = 5'd7; ifid_rt = 5'd2;
    #3;
    chk("lu_rs_stall", 32'(ctrl), 32'(C_STALL));
    tick();
    idex_memread = 1'b0;
    tick();
    chk("lu_rs_stall_cnt", 32'(stall_count), 32'd2);

    // No false stall: lw does not read rt; idex_rt==0 never stalls
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_opcode = 6'b100011; ifid_rt = 5'd5; ifid_rs = 5'd3;
    #3;
    chk("nofalse_lw", 32'(ctrl), 32'(C_RUN));
    tick();
    idex_rt = 5'd0; ifid_opcode = 6'b000000; ifid_rt = 5'd0; ifid_rs = 5'd0;
    #3;
    chk("nofalse_r0", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("nofalse_stall_cnt", 32'(stall_count), 32'd2);

    // Branch and load-use together: flush only, stall count unchanged
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_opcode = 6'b000000; ifid_rt = 5'd5; ifid_rs = 5'd1;
    ex_branch_taken = 1'b1;
    #3;
    chk("br_lu_flush", 32'(ctrl), 32'(C_FLUSH));
    tick();
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_count), 32'd2);
    ex_branch_taken = 1'b0;
    #3;
    chk("flush_suppress_lu", 32'(ctrl), 32'(C_RUN));
    tick();
    #3;
    chk("post_flush_lu", 32'(ctrl), 32'(C_STALL));
    tick();
    idex_memread = 1'b0;
    tick();
    chk("post_flush_stall_cnt", 32'(stall_count), 32'd3);
    chk("post_flush_flush_cnt", 32'(flush_count), 32'd1);

    // Memory wait for 4 cycles
    quiet();
    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("mw_hold_%0d", i), 32'(ctrl), 32'(C_HOLD));
      tick();
    end
    dmem_busy = 1'b0;
    #3;
    chk("mw_release", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("mw_stall_cnt", 32'(stall_count), 32'd7);
    chk("mw_no_error", 32'(mem_error), 32'd0);

    // Timeout: busy for 20 cycles; wait cycles are cycles 1..15, release on cycle 15
    dmem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #3;
      chk($sformatf("to_ctrl_%0d", i), 32'(ctrl), (i == 15) ? 32'(C_RUN) : 32'(C_HOLD));
      chk($sformatf("to_err_%0d", i), 32'(mem_error), (i > 15) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_busy = 1'b0;
    #3;
    chk("to_after_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("to_sticky", 32'(mem_error), 32'd1);
    chk("to_stall_cnt", 32'(stall_count), 32'd26);

    // Reset in the middle of MEM_WAIT
    dmem_busy = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mw_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("rst_mw_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_mw_flush_cnt", 32'(flush_count), 32'd0);
    chk("rst_mw_err", 32'(mem_error), 32'd0);
    dmem_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    #3;
    chk("rst_mw_release", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("rst_mw_err_after", 32'(mem_error), 32'd0);
    chk("rst_mw_stall_after", 32'(stall_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles spent in MEM_WAIT before mem_error is raised.
REQ-002 Parameter CNT_W, default 16, is the width of the stall and flush counters.
REQ-003 Ports SHALL be, with clock and reset first:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ifid_opcode  in  6  opcode held in the IF/ID register
- ifid_rs  in  5  rs held in IF/ID
- ifid_rt  in  5  rt held in IF/ID
- idex_memread  in  1  instruction in ID/EX is a load
- idex_rt  in  5  load destination in ID/EX
- ex_branch_taken  in  1  beq resolved taken in EX
- dmem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable (drives IFIDWrite)
- ifid_flush  out  1  IF/ID load of NOP
- idex_bubble  out  1  zero ID/EX control fields
- exmem_hold  out  1  freeze EX/MEM and later stages
- mem_error  out  1  sticky timeout flag
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of flush events

Function
REQ-004 The FSM SHALL have four states: RUN, LOAD_STALL, MEM_WAIT and FLUSH, with an encoding of 2 bits.
REQ-005 "uses_rt" SHALL be true for opcodes 000000, 101011 and 000100, and false for all others (100011, 001001, 001010 and jumps).
REQ-006 "load_use" SHALL be true when idex_memread=1, idex_rt!=0, and either idex_rt==ifid_rs or (uses_rt and idex_rt==ifid_rt).
REQ-007 Outputs SHALL be combinational from the current state and inputs (Mealy); the hazard acts in the same cycle it is detected.
REQ-008 The event priority in every state SHALL be dmem_busy > ex_branch_taken > load_use > none.
REQ-009 In RUN with no event: pc_write=1, ifid_write=1, and all other controls 0.
REQ-010 When dmem_busy=1 in any state: pc_write=0, ifid_write=0 and exmem_hold=1; the next state is MEM_WAIT and the wait counter is cleared on entry.
REQ-011 In MEM_WAIT: the same holds apply while dmem_busy=1 and the wait counter increments.
- On dmem_busy=0 the next state is RUN.
- When the wait counter reaches MEM_TIMEOUT, set mem_error=1 (sticky), release all holds and go to RUN.
REQ-012 When ex_branch_taken=1 with no dmem_busy: pc_write=1, ifid_flush=1, idex_bubble=1 and ifid_write=1 (NOP loaded); the next state is FLUSH.
REQ-013 In FLUSH: behave as RUN for exactly one cycle, while suppressing a load_use generated by the flushed slot (idex_memread is ignored); the next state is RUN.
REQ-014 When load_use=1 with no higher event: pc_write=0, ifid_write=0 and idex_bubble=1; the next state is LOAD_STALL.
REQ-015 In LOAD_STALL: if load_use is still true, repeat REQ-014 behaviour; otherwise behave as RUN and return to RUN.
REQ-016 ifid_flush and ifid_write=0 SHALL never be asserted in the same cycle; flush takes precedence over load stall.
REQ-017 stall_count SHALL increment in every cycle with pc_write=0, saturating at all ones.
REQ-018 flush_count SHALL increment once per ifid_flush assertion, saturating at all ones.
REQ-019 When ex_branch_taken and load_use occur simultaneously, only the flush SHALL be performed and stall_count SHALL be unchanged.

Reset
REQ-020 When reset_n=0, asynchronously: state=RUN, wait counter=0, mem_error=0, stall_count=0, flush_count=0.
REQ-021 While reset_n=0: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0 and exmem_hold=0.
REQ-022 Reset asserted mid-MEM_WAIT or mid-LOAD_STALL SHALL abandon the state without raising mem_error; the first cycle after release follows REQ-009.

Structure
REQ-023 The opcode constants (R-type 000000, lw 100011, sw 101011, 001001, 001010, beq 000100) and the state encoding SHALL live in a shared package, also used by the pipeline registers.
REQ-024 A single sub-module, sat_counter (parameter CNT_W, inc, clear), SHALL implement both counters; all other logic stays flat.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Load-use: idex_memread=1, idex_rt=5, ifid_opcode=000000, ifid_rt=5 -> one cycle with pc_write=0, ifid_write=0 and idex_bubble=1, then RUN; stall_count=1.
- No false stall: idex_rt=5, ifid_opcode=100011, ifid_rt=5, ifid_rs=3 -> pc_write=1 with no bubble; idex_rt=0 likewise gives no stall.
- Branch with load-use in the same cycle: ex_branch_taken=1 and load_use=1 -> ifid_flush=1 and pc_write=1; flush_count=1, stall_count=0; FLUSH lasts one cycle.
- Memory wait: dmem_busy=1 for 4 cycles -> exmem_hold=1 and pc_write=0 for 4 cycles, RUN on the 5th cycle; stall_count=4.
- Timeout: dmem_busy held high for 20 cycles with MEM_TIMEOUT=15 -> mem_error=1 after the 15th wait cycle and remains 1 after dmem_busy falls.
- Reset: reset_n pulsed low during MEM_WAIT -> all outputs and counters are 0 immediately; after release, pc_write=1.
